// File: rtl/toggle_port_pkg.sv
// rtl/toggle_port_pkg.sv - shared types for the toggle-handshake memory port responder
package toggle_port_pkg;

  // Widest word address a port may carry; requests are zero-extended to this.
  localparam int REQ_AW_MAX = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    PORT1 = 1'b0,
    PORT2 = 1'b1
  } port_sel_e;

  typedef struct packed {
    logic [REQ_AW_MAX-1:0] a;
    logic [1:0]            ds;
    logic                  we;
    logic [15:0]           d;
  } req_t;

  // Round-robin pick: a lone pending port wins; on a tie the port not served last wins.
  function automatic port_sel_e arbitrate(input logic pend1, input logic pend2,
                                          input port_sel_e last);
    if (pend1 && pend2) begin
      return (last == PORT1) ? PORT2 : PORT1;
    end else if (pend1) begin
      return PORT1;
    end else begin
      return PORT2;
    end
  endfunction

endpackage

// File: rtl/toggle_port_slot.sv
// rtl/toggle_port_slot.sv - one toggle-handshake port: pending detect, request capture, ack and read data
module toggle_port_slot
  import toggle_port_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          req,
  input  logic [AW-1:0] a,
  input  logic [1:0]    ds,
  input  logic          we,
  input  logic [15:0]   d,
  input  logic          grant,
  input  logic          finish,
  input  logic          load,
  input  logic [15:0]   rdata,
  output logic          pend,
  output logic          ack,
  output logic [15:0]   q,
  output req_t          live,
  output req_t          cap
);

  assign live = '{a: REQ_AW_MAX'(a), ds: ds, we: we, d: d};
  assign pend = req ^ ack;

  // Capture the request at grant, toggle ack on completion, load q on read completion.
  // Reset copies req into ack so no stale toggle is left pending.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ack <= req;
      q   <= '0;
      cap <= '0;
    end else begin
      if (grant) begin
        cap <= live;
      end
      if (finish) begin
        ack <= ~ack;
      end
      if (load) begin
        q <= rdata;
      end
    end
  end

endmodule

// File: rtl/toggle_port_responder.sv
// rtl/toggle_port_responder.sv - two toggle-handshake ports arbitrated onto one 16-bit block RAM
module toggle_port_responder
  import toggle_port_pkg::*;
#(
  parameter int AW     = 15,
  parameter int RD_LAT = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          port1_req,
  output logic          port1_ack,
  input  logic [AW-1:0] port1_a,
  input  logic [1:0]    port1_ds,
  input  logic          port1_we,
  input  logic [15:0]   port1_d,
  output logic [15:0]   port1_q,
  input  logic          port2_req,
  output logic          port2_ack,
  input  logic [AW-1:0] port2_a,
  input  logic [1:0]    port2_ds,
  input  logic          port2_we,
  input  logic [15:0]   port2_d,
  output logic [15:0]   port2_q,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_be,
  output logic          mem_we,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
);

  // Last WAIT cycle index; the read data is sampled on the edge that leaves it.
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_e    state, state_nxt;
  port_sel_e last, sel, pick;
  logic [1:0] cnt;
  logic pend1, pend2;
  logic grant1, grant2, finish1, finish2;
  req_t live1, live2, cap1, cap2, inc, cur;
  logic unused_addr_hi;

  toggle_port_slot #(.AW(AW)) u_slot1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req     (port1_req),
    .a       (port1_a),
    .ds      (port1_ds),
    .we      (port1_we),
    .d       (port1_d),
    .grant   (grant1),
    .finish  (finish1),
    .load    (finish1 & ~cur.we),
    .rdata   (mem_rdata),
    .pend    (pend1),
    .ack     (port1_ack),
    .q       (port1_q),
    .live    (live1),
    .cap     (cap1)
  );

  toggle_port_slot #(.AW(AW)) u_slot2 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req     (port2_req),
    .a       (port2_a),
    .ds      (port2_ds),
    .we      (port2_we),
    .d       (port2_d),
    .grant   (grant2),
    .finish  (finish2),
    .load    (finish2 & ~cur.we),
    .rdata   (mem_rdata),
    .pend    (pend2),
    .ack     (port2_ack),
    .q       (port2_q),
    .live    (live2),
    .cap     (cap2)
  );

  assign pick = arbitrate(pend1, pend2, last);
  assign inc  = (pick == PORT1) ? live1 : live2;
  assign cur  = (sel == PORT1) ? cap1 : cap2;

  // Address bits above AW are always zero after extension.
  assign unused_addr_hi = ^{inc.a, cur.a};

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus one-cycle grant and finish strobes for the selected port.
  always_comb begin
    state_nxt = state;
    grant1    = 1'b0;
    grant2    = 1'b0;
    finish1   = 1'b0;
    finish2   = 1'b0;
    case (state)
      IDLE: begin
        if (pend1 || pend2) begin
          state_nxt = ACCESS;
          grant1    = (pick == PORT1);
          grant2    = (pick == PORT2);
        end
      end
      ACCESS: state_nxt = WAIT;
      WAIT: begin
        if (cnt == LAT_LAST) begin
          state_nxt = DONE;
          finish1   = (sel == PORT1);
          finish2   = (sel == PORT2);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Served-port tracking for round-robin and the read-latency counter.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last <= PORT2;
      sel  <= PORT2;
      cnt  <= 2'd0;
    end else begin
      if (grant1 || grant2) begin
        sel  <= pick;
        last <= pick;
      end
      cnt <= (state == WAIT) ? cnt + 2'd1 : 2'd0;
    end
  end

  // Memory outputs: loaded straight from the winning port at grant so the address
  // is out one cycle earlier, then held from the captured request.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (grant1 || grant2) begin
        mem_addr  <= AW'(inc.a);
        mem_be    <= inc.ds;
        mem_wdata <= inc.d;
        mem_we    <= inc.we & (|inc.ds);
      end else begin
        mem_addr  <= AW'(cur.a);
        mem_be    <= cur.ds;
        mem_wdata <= cur.d;
      end
    end
  end

endmodule

// File: tb/tb_toggle_port_responder.sv
// tb/tb_toggle_port_responder.sv - scoreboard bench for toggle_port_responder at RD_LAT 1 and 3
module tb_toggle_port_responder;
  import toggle_port_pkg::*;

  localparam int AW = 15;

  typedef struct {
    int          cyc;
    logic [15:0] q;
  } exp_t;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          reset;
  logic          req [4];
  logic [AW-1:0] pa  [4];
  logic [1:0]    pds [4];
  logic          pwe [4];
  logic [15:0]   pd  [4];
  logic [3:0]    ack_v;
  logic [15:0]   q_v [4];
  logic [3:0]    prev_ack;

  logic [AW-1:0] a_mem_addr, b_mem_addr;
  logic [1:0]    a_mem_be, b_mem_be;
  logic          a_mem_we, b_mem_we;
  logic [15:0]   a_mem_wdata, b_mem_wdata, a_rdata, b_rdata;
  logic [15:0]   mem_a [0:(1<<AW)-1];
  logic [15:0]   mem_b [0:(1<<AW)-1];
  logic [15:0]   a_r1, b_r1, b_r2, b_r3;

  int   cyc = 0;
  int   a_wcnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb [4][$];

  toggle_port_responder #(.AW(AW), .RD_LAT(1)) dut_a (
    .clk_sys (clk_sys), .reset (reset),
    .port1_req (req[0]), .port1_ack (ack_v[0]), .port1_a (pa[0]), .port1_ds (pds[0]),
    .port1_we (pwe[0]), .port1_d (pd[0]), .port1_q (q_v[0]),
    .port2_req (req[1]), .port2_ack (ack_v[1]), .port2_a (pa[1]), .port2_ds (pds[1]),
    .port2_we (pwe[1]), .port2_d (pd[1]), .port2_q (q_v[1]),
    .mem_addr (a_mem_addr), .mem_be (a_mem_be), .mem_we (a_mem_we),
    .mem_wdata (a_mem_wdata), .mem_rdata (a_rdata)
  );

  toggle_port_responder #(.AW(AW), .RD_LAT(3)) dut_b (
    .clk_sys (clk_sys), .reset (reset),
    .port1_req (req[2]), .port1_ack (ack_v[2]), .port1_a (pa[2]), .port1_ds (pds[2]),
    .port1_we (pwe[2]), .port1_d (pd[2]), .port1_q (q_v[2]),
    .port2_req (req[3]), .port2_ack (ack_v[3]), .port2_a (pa[3]), .port2_ds (pds[3]),
    .port2_we (pwe[3]), .port2_d (pd[3]), .port2_q (q_v[3]),
    .mem_addr (b_mem_addr), .mem_be (b_mem_be), .mem_we (b_mem_we),
    .mem_wdata (b_mem_wdata), .mem_rdata (b_rdata)
  );

  always @(posedge clk_sys) cyc <= cyc + 1;

  // RAM behind dut_a: byte-enabled write, one-cycle read.
  always @(posedge clk_sys) begin
    if (a_mem_we) begin
      if (a_mem_be[1]) mem_a[a_mem_addr][15:8] <= a_mem_wdata[15:8];
      if (a_mem_be[0]) mem_a[a_mem_addr][7:0]  <= a_mem_wdata[7:0];
      a_wcnt <= a_wcnt + 1;
    end
    a_r1 <= mem_a[a_mem_addr];
  end
  assign a_rdata = a_r1;

  // RAM behind dut_b: byte-enabled write, three-cycle read.
  always @(posedge clk_sys) begin
    if (b_mem_we) begin
      if (b_mem_be[1]) mem_b[b_mem_addr][15:8] <= b_mem_wdata[15:8];
      if (b_mem_be[0]) mem_b[b_mem_addr][7:0]  <= b_mem_wdata[7:0];
    end
    b_r1 <= mem_b[b_mem_addr];
    b_r2 <= b_r1;
    b_r3 <= b_r2;
  end
  assign b_rdata = b_r3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    return sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic drive(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [1:0] ds, input logic [15:0] d);
    pa[p]  = a;
    pds[p] = ds;
    pwe[p] = we;
    pd[p]  = d;
    req[p] = ~req[p];
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [1:0] ds, input logic [15:0] d,
                       input int lat, input logic [15:0] q_exp);
    exp_t e;
    drive(p, we, a, ds, d);
    e.cyc = cyc + lat;
    e.q   = q_exp;
    sb[p].push_back(e);
  endtask

  task automatic drain(input string tag, input int budget, input bit watch_bq1);
    for (int k = 0; k < budget && pending() != 0; k++) begin
      @(negedge clk_sys);
      if (watch_bq1) check("b_port1_q_stable", q_v[2], 32'h0);
    end
    check({tag, "_drained"}, pending(), 0);
    tick(1);
  endtask

  task automatic ack_event(input int i);
    exp_t e;
    check($sformatf("port%0d_ack_expected", i), 32'(sb[i].size() > 0), 1);
    if (sb[i].size() > 0) begin
      e = sb[i].pop_front();
      check($sformatf("port%0d_ack_cycle", i), cyc, e.cyc);
      check($sformatf("port%0d_q", i), q_v[i], e.q);
    end
  endtask

  // Every ack toggle outside reset must match the oldest expectation for that port.
  always @(negedge clk_sys) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (ack_v[i] !== prev_ack[i]) ack_event(i);
      end
    end
    prev_ack <= ack_v;
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0; pa[i] = '0; pds[i] = 2'b00; pwe[i] = 1'b0; pd[i] = 16'h0;
    end
    req[0] = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("rst_port1_ack", ack_v[0], 1);
    check("rst_port2_ack", ack_v[1], 0);
    check("rst_port1_q", q_v[0], 0);
    check("rst_port2_q", q_v[1], 0);
    check("rst_mem_we", a_mem_we, 0);
    check("rst_mem_addr", a_mem_addr, 0);
    tick(4);
    check("rst_no_access", a_wcnt, 0);
    check("rst_state_idle", 32'(dut_a.state), 32'(IDLE));

    issue(0, 1'b1, 15'h010, 2'b11, 16'hBEEF, 3, 16'h0000);
    drain("p1_write", 20, 1'b0);
    check("p1_write_mem", mem_a[15'h010], 16'hBEEF);
    check("p1_write_pulses", a_wcnt, 1);

    issue(0, 1'b0, 15'h010, 2'b11, 16'h0000, 3, 16'hBEEF);
    drain("p1_read", 20, 1'b0);

    issue(1, 1'b1, 15'h010, 2'b01, 16'h1234, 3, 16'h0000);
    drain("p2_write_lo", 20, 1'b0);
    check("p2_write_lo_mem", mem_a[15'h010], 16'hBE34);
    check("p2_write_lo_pulses", a_wcnt, 2);

    issue(1, 1'b1, 15'h010, 2'b00, 16'hFFFF, 3, 16'h0000);
    drain("p2_write_none", 20, 1'b0);
    check("p2_write_none_mem", mem_a[15'h010], 16'hBE34);
    check("p2_write_none_pulses", a_wcnt, 2);

    issue(1, 1'b1, 15'h020, 2'b11, 16'hC0DE, 3, 16'h0000);
    drain("p2_write_full", 20, 1'b0);

    issue(0, 1'b0, 15'h010, 2'b11, 16'h0000, 3, 16'hBE34);
    issue(1, 1'b0, 15'h020, 2'b11, 16'h0000, 7, 16'hC0DE);
    drain("tie1", 30, 1'b0);

    issue(0, 1'b0, 15'h020, 2'b11, 16'h0000, 3, 16'hC0DE);
    issue(1, 1'b0, 15'h010, 2'b11, 16'h0000, 7, 16'hBE34);
    drain("tie2", 30, 1'b0);

    issue(0, 1'b1, 15'h030, 2'b10, 16'hAB00, 3, 16'hC0DE);
    drain("p1_write_hi", 20, 1'b0);
    check("p1_write_hi_pulses", a_wcnt, 4);
    issue(0, 1'b0, 15'h010, 2'b11, 16'h0000, 7, 16'hBE34);
    issue(1, 1'b0, 15'h020, 2'b11, 16'h0000, 3, 16'hC0DE);
    drain("tie3", 30, 1'b0);

    issue(0, 1'b0, 15'h020, 2'b11, 16'h0000, 3, 16'hC0DE);
    tick(1);
    pa[0] = 15'h010; pwe[0] = 1'b1; pds[0] = 2'b11; pd[0] = 16'h0000;
    drain("capture", 20, 1'b0);
    check("capture_mem", mem_a[15'h010], 16'hBE34);
    check("capture_pulses", a_wcnt, 4);

    issue(0, 1'b0, 15'h010, 2'b11, 16'h0000, 3, 16'hBE34);
    tick(3);
    issue(0, 1'b0, 15'h020, 2'b11, 16'h0000, 4, 16'hC0DE);
    drain("retoggle", 30, 1'b0);

    issue(3, 1'b1, 15'h040, 2'b11, 16'h5A5A, 5, 16'h0000);
    drain("lat3_write", 30, 1'b1);
    check("lat3_write_mem", mem_b[15'h040], 16'h5A5A);
    issue(3, 1'b0, 15'h040, 2'b11, 16'h0000, 5, 16'h5A5A);
    drain("lat3_read", 30, 1'b1);

    drive(0, 1'b0, 15'h010, 2'b11, 16'h0000);
    tick(2);
    check("abort_in_wait", 32'(dut_a.state), 32'(WAIT));
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("abort_port1_ack", ack_v[0], req[0]);
    check("abort_port2_ack", ack_v[1], req[1]);
    check("abort_state_idle", 32'(dut_a.state), 32'(IDLE));
    check("abort_port1_q", q_v[0], 0);
    tick(5);
    check("abort_no_ack", pending(), 0);
    check("abort_mem_we", a_mem_we, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_port_responder.md
# toggle_port_responder

Responder end of the toggle request/acknowledge memory-port protocol our top levels use for ROM download and vector RAM traffic. It services two independent toggle-handshake ports: a request is pending while `portN_req != portN_ack`. Requests are arbitrated round-robin onto one synchronous single-port 16-bit block RAM with byte enables. The block is the on-chip alternative to routing a port through the SDRAM controller, used for vector RAM on boards where SDRAM bandwidth is short.

## Interface
Parameters:
- `AW`, 15: word address width of both ports and of the memory.
- `RD_LAT`, 1: memory read latency in cycles; legal range 1–3.

Ports:
- `clk_sys`  in  1: single clock; every port is synchronous to it.
- `reset`  in  1: synchronous, active-high reset.
- `port1_req`  in  1: request toggle from the port-1 initiator.
- `port1_ack`  out  1: acknowledge toggle; set equal to `port1_req` on completion.
- `port1_a`  in  AW: word address.
- `port1_ds`  in  2: byte strobes; bit 1 selects [15:8], bit 0 selects [7:0].
- `port1_we`  in  1: 1 = write, 0 = read.
- `port1_d`  in  16: write data.
- `port1_q`  out  16: read data, valid once ack has toggled.
- `port2_req`, `port2_ack`, `port2_a`, `port2_ds`, `port2_we`, `port2_d`, `port2_q`: same as port 1.
- `mem_addr`  out  AW: memory address, registered.
- `mem_be`  out  2: memory byte enables, registered.
- `mem_we`  out  1: memory write strobe, registered, one-cycle pulse.
- `mem_wdata`  out  16: memory write data, registered.
- `mem_rdata`  in  16: memory read data, valid `RD_LAT` cycles after the address is presented.

## Operation
- Pending condition: `pendN = portN_req ^ portN_ack`.
- Initiator protocol: hold a/ds/we/d stable and do not toggle req again until ack matches. A violation of this rule has undefined results.
- States:
  - IDLE: if any port is pending, grant it and go to ACCESS.
  - ACCESS: one cycle; drives mem_* from the captured request; go to WAIT.
  - WAIT: count `RD_LAT` cycles; go to DONE.
  - DONE: for a read, load `portN_q` from `mem_rdata`. Toggle `portN_ack` in either case. Go to IDLE.
- Arbitration:
  - If only one port is pending, grant it.
  - If both are pending, grant the port not served last. The last-served flag resets to port 2, so port 1 wins the first tie.
- Requests are captured at grant. Inputs changing after grant have no effect on the access in flight.
- Write with `ds = 00`: `mem_we` stays 0 and ack still toggles. No ds combination is an error.
- A write leaves `portN_q` unchanged. A read returns the full 16-bit word regardless of ds.
- The q of the port not being served never changes.
- `mem_we` is 1 only in ACCESS of a write with nonzero ds. `mem_be` equals the captured ds.

## Timing
- Reset values:
  - state IDLE, last-served = port 2.
  - `portN_ack` loads the current `portN_req`, so nothing is pending after reset.
  - `portN_q` = 0; all mem_* = 0.
- Reset mid-operation: the access is abandoned and ack is resynchronised to req. A write already pulsed is not undone.
- Latency: req toggles at edge E0.
  - Grant at E1; mem_* valid after E1.
  - Data captured and ack toggled at E(2+`RD_LAT`). That is 3 cycles for `RD_LAT=1`.
  - Writes use the same latency.
- Throughput: one access every `3+RD_LAT` cycles. The block returns to IDLE before it re-arbitrates.
- Simultaneous toggles on both ports: served back-to-back. The second ack arrives `3+RD_LAT` cycles after the first.
- A req toggle arriving in the same cycle its own ack toggles is seen as a new request in IDLE.

## Structure
- Package `toggle_port_pkg`: state enum (IDLE/ACCESS/WAIT/DONE), port-select type, and a captured-request struct {a, ds, we, d}.
- Sub-module `toggle_port_slot`, instantiated twice. Per port it holds the pending detect, the request capture register, the ack toggle flop and the q register.
- Arbiter, state machine and latency counter live in the top module.

## Test plan
- Reset with `port1_req=1`, `port2_req=0` → after reset, `port1_ack=1`, `port2_ack=0`, no memory access issued.
- Port 1 write `a=0x0010`, `ds=11`, `d=0xBEEF`, then a read of the same address → ack toggles after 3 cycles each; `port1_q=0xBEEF`.
- Port 2 write `ds=01`, `d=0x1234` over stored `0xBEEF` → memory word becomes `0xBE34`; `port2_q` unchanged. A following `ds=00` write changes nothing and is still acked.
- Both ports toggle in the same cycle → port 1 acked at E3, port 2 acked at E7. A repeat tie is won by port 1 again only if port 2 was served last.
- `RD_LAT=3`, port 2 read → ack at E5 with correct data; `port1_q` stable throughout.
- Reset asserted in WAIT → no further ack toggle; `ack==req` on both ports and state IDLE after reset.
